tanh_in_requant_acc: RTL and testbench



---
 rtl/tanh_act_pkg.sv | 49 ++++
 rtl/act_round_sat.sv | 21 ++
 rtl/tanh_in_requant_acc.sv | 94 +++++++++
 tb/tb_tanh_in_requant_acc.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tanh_act_pkg.sv
// Shared definitions for the 4-bit tanh activation front end: code range,
// a constant clog2 helper and the round/shift/clamp function that the
// 3-, 4- and 5-bit activation variants all reuse.
package tanh_act_pkg;

    localparam int ACT_IN_W = 4;
    localparam int ACT_MIN  = -8;
    localparam int ACT_MAX  = 7;

    // Rounded, clamped activation code together with its clip flag.
    typedef struct packed {
        logic [ACT_IN_W-1:0] code;
        logic                sat;
    } sat_code_t;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

    // Round half toward +inf, arithmetic shift right, then clamp to the
    // activation input range. The caller sign-extends its sum to 32 bits.
    function automatic sat_code_t sat_round(input logic signed [31:0] sum,
                                            input int shift);
        logic signed [31:0] rnd;
        sat_code_t          res;
        rnd = (sum + (32'sd1 <<< (shift - 1))) >>> shift;
        if (rnd > ACT_MAX) begin
            res.code = ACT_IN_W'(ACT_MAX);
            res.sat  = 1'b1;
        end else if (rnd < ACT_MIN) begin
            res.code = ACT_IN_W'(ACT_MIN);
            res.sat  = 1'b1;
        end else begin
            res.code = rnd[ACT_IN_W-1:0];
            res.sat  = 1'b0;
        end
        return res;
    endfunction

endpackage

// File: rtl/act_round_sat.sv
// Purely combinational requantiser: rounds, shifts and clamps a signed
// accumulator value into the 4-bit activation code.
module act_round_sat
    import tanh_act_pkg::*;
#(
    parameter int ACC_W = 10,
    parameter int SHIFT = 4
) (
    input  logic signed [ACC_W-1:0]    sum,
    output logic        [ACT_IN_W-1:0] code,
    output logic                       sat
);

    sat_code_t res;

    // Sign-extend the sum so the shared function sees the true value.
    assign res  = sat_round(32'(sum), SHIFT);
    assign code = res.code;
    assign sat  = res.sat;

endmodule

// File: rtl/tanh_in_requant_acc.sv
// Accumulates N_TERMS signed products per neuron, requantises the finished
// sum to a 4-bit saturated code and offers it through a one-entry output
// register with valid/ready handshaking on both sides.
module tanh_in_requant_acc
    import tanh_act_pkg::*;
#(
    parameter int IN_W    = 8,
    parameter int N_TERMS = 4,
    parameter int SHIFT   = 4,
    parameter int OUT_W   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [IN_W-1:0]       s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [OUT_W-1:0]             m_data,
    output logic                         m_sat,
    output logic [clog2(N_TERMS)-1:0]    cnt_o
);

    localparam int CNT_W = clog2(N_TERMS);
    // Wide enough that N_TERMS full-scale products cannot overflow.
    localparam int ACC_W = IN_W + CNT_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TERMS - 1);

    logic signed [ACC_W-1:0]    acc_reg;
    logic        [CNT_W-1:0]    cnt_reg;
    logic                       m_valid_reg;
    logic        [OUT_W-1:0]    m_data_reg;
    logic                       m_sat_reg;

    logic signed [ACC_W-1:0]    sum_next;
    logic        [ACT_IN_W-1:0] code_next;
    logic                       sat_next;
    logic                       cnt_last;
    logic                       accept;
    logic                       complete;

    assign cnt_last = (cnt_reg == CNT_LAST);
    // Only the completing term has to wait for the output register.
    assign s_ready  = !(cnt_last && m_valid_reg && !m_ready);
    assign accept   = s_valid && s_ready;
    assign complete = accept && cnt_last;
    assign sum_next = acc_reg + ACC_W'(s_data);

    act_round_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_round_sat (
        .sum  (sum_next),
        .code (code_next),
        .sat  (sat_next)
    );

    // Accumulator and term counter; both restart on the completing term.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else if (accept) begin
            if (cnt_last) begin
                acc_reg <= '0;
                cnt_reg <= '0;
            end else begin
                acc_reg <= sum_next;
                cnt_reg <= cnt_reg + CNT_W'(1);
            end
        end
    end

    // One-entry output register: a new result may replace one being drained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_reg <= 1'b0;
            m_data_reg  <= '0;
            m_sat_reg   <= 1'b0;
        end else if (complete) begin
            m_valid_reg <= 1'b1;
            m_data_reg  <= OUT_W'(code_next);
            m_sat_reg   <= sat_next;
        end else if (m_ready) begin
            m_valid_reg <= 1'b0;
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = m_data_reg;
    assign m_sat   = m_sat_reg;
    assign cnt_o   = cnt_reg;

endmodule

// File: tb/tb_tanh_in_requant_acc.sv
// Directed and lightly randomised checks for the tanh input requantiser.
module tb_tanh_in_requant_acc;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              s_valid = 1'b0;
    logic              s_ready;
    logic signed [7:0] s_data = '0;
    logic              m_valid;
    logic              m_ready = 1'b1;
    logic [3:0]        m_data;
    logic              m_sat;
    logic [1:0]        cnt_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int t0;
        int t1;
        int t2;
        int t3;
        int exp_data;
        int exp_sat;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    int exp_code_q [$];
    int exp_sat_q  [$];

    tanh_in_requant_acc #(
        .IN_W    (8),
        .N_TERMS (4),
        .SHIFT   (4),
        .OUT_W   (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sat   (m_sat),
        .cnt_o   (cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Returns 1 ns after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int term(input vec_t v, input int k);
        case (k)
            0:       return v.t0;
            1:       return v.t1;
            2:       return v.t2;
            default: return v.t3;
        endcase
    endfunction

    function automatic int floor_div16(input int x);
        if (x >= 0) return x / 16;
        return -((-x + 15) / 16);
    endfunction

    function automatic int ref_code(input int sum);
        int r;
        r = floor_div16(sum + 8);
        if (r > 7) r = 7;
        if (r < -8) r = -8;
        return r;
    endfunction

    function automatic int ref_sat(input int sum);
        int r;
        r = floor_div16(sum + 8);
        return (r > 7 || r < -8) ? 1 : 0;
    endfunction

    function automatic int sdata();
        return int'($signed(m_data));
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int mc;
        int msum;
        int e_code;
        int e_sat;
        int n_out;

        vecs[0]  = '{10, 20, 30, -4, 4, 0};
        vecs[1]  = '{2, 2, 2, 2, 1, 0};
        vecs[2]  = '{7, 0, 0, 0, 0, 0};
        vecs[3]  = '{-9, 0, 0, 0, -1, 0};
        vecs[4]  = '{-2, -2, -2, -2, 0, 0};
        vecs[5]  = '{127, 127, 127, 127, 7, 1};
        vecs[6]  = '{-128, -128, -128, -128, -8, 1};
        vecs[7]  = '{100, 20, 0, 0, 7, 1};
        vecs[8]  = '{100, 19, 0, 0, 7, 0};
        vecs[9]  = '{-128, -8, 0, 0, -8, 0};
        vecs[10] = '{-128, -9, 0, 0, -8, 1};

        // Reset state
        #2;
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", sdata(), 0);
        chk("rst_m_sat", int'(m_sat), 0);
        chk("rst_cnt", int'(cnt_o), 0);
        #10 rst_n = 1'b1;
        #1;
        chk("rst_s_ready", int'(s_ready), 1);
        tick();

        // Back-to-back vectors with m_ready held high
        for (int v = 0; v < NVEC; v++) begin
            for (int k = 0; k < 4; k++) begin
                s_valid = 1'b1;
                s_data  = 8'(term(vecs[v], k));
                tick();
                chk($sformatf("vec%0d_cnt%0d", v, k), int'(cnt_o), (k + 1) % 4);
                if (k < 3) begin
                    chk($sformatf("vec%0d_idle%0d", v, k), int'(m_valid), 0);
                end else begin
                    $display("vec %0d: m_data=%0d m_sat=%0d", v, sdata(), m_sat);
                    chk($sformatf("vec%0d_valid", v), int'(m_valid), 1);
                    chk($sformatf("vec%0d_data", v), sdata(), vecs[v].exp_data);
                    chk($sformatf("vec%0d_sat", v), int'(m_sat), vecs[v].exp_sat);
                end
            end
        end
        s_valid = 1'b0;
        s_data  = 8'sd99;
        tick();
        chk("drain_valid", int'(m_valid), 0);
        chk("hold_data", sdata(), vecs[NVEC-1].exp_data);
        tick();
        chk("ignore_invalid_cnt", int'(cnt_o), 0);

        // Backpressure: result held while the next vector's first terms land
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = 8'sd16;
            tick();
        end
        chk("bp_first_valid", int'(m_valid), 1);
        chk("bp_first_data", sdata(), 4);
        for (int k = 0; k < 3; k++) begin
            s_data = 8'sd32;
            tick();
            chk($sformatf("bp_hold_valid%0d", k), int'(m_valid), 1);
            chk($sformatf("bp_hold_data%0d", k), sdata(), 4);
            chk($sformatf("bp_cnt%0d", k), int'(cnt_o), k + 1);
        end
        s_data = 8'sd32;
        #1;
        chk("bp_stall_ready", int'(s_ready), 0);
        tick();
        chk("bp_stall_cnt", int'(cnt_o), 3);
        chk("bp_stall_data", sdata(), 4);
        m_ready = 1'b1;
        #1;
        chk("bp_release_ready", int'(s_ready), 1);
        tick();
        m_ready = 1'b0;
        s_valid = 1'b0;
        $display("backpressure: m_data=%0d m_sat=%0d", sdata(), m_sat);
        chk("bp_second_valid", int'(m_valid), 1);
        chk("bp_second_data", sdata(), 7);
        chk("bp_second_sat", int'(m_sat), 1);
        chk("bp_second_cnt", int'(cnt_o), 0);
        tick();
        chk("bp_second_held", int'(m_valid), 1);
        m_ready = 1'b1;
        tick();
        chk("bp_drained", int'(m_valid), 0);

        // Random bubbles and backpressure against a reference model
        mc    = 0;
        msum  = 0;
        n_out = 0;
        for (int c = 0; c < 400; c++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_data  = 8'($urandom_range(0, 255));
            m_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd_s_ready", int'(s_ready), (mc == 3 && m_valid && !m_ready) ? 0 : 1);
            if (m_valid && m_ready) begin
                if (exp_code_q.size() == 0) begin
                    chk("rnd_extra_output", 1, 0);
                end else begin
                    e_code = exp_code_q.pop_front();
                    e_sat  = exp_sat_q.pop_front();
                    $display("rnd out %0d: m_data=%0d m_sat=%0d", n_out, sdata(), m_sat);
                    chk("rnd_data", sdata(), e_code);
                    chk("rnd_sat", int'(m_sat), e_sat);
                    n_out++;
                end
            end
            if (s_valid && s_ready) begin
                msum += int'(s_data);
                mc++;
                if (mc == 4) begin
                    exp_code_q.push_back(ref_code(msum));
                    exp_sat_q.push_back(ref_sat(msum));
                    mc   = 0;
                    msum = 0;
                end
            end
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (m_valid && m_ready && exp_code_q.size() != 0) begin
                e_code = exp_code_q.pop_front();
                e_sat  = exp_sat_q.pop_front();
                $display("rnd out %0d: m_data=%0d m_sat=%0d", n_out, sdata(), m_sat);
                chk("rnd_drain_data", sdata(), e_code);
                chk("rnd_drain_sat", int'(m_sat), e_sat);
                n_out++;
            end
            tick();
        end
        chk("rnd_leftover", exp_code_q.size(), 0);
        chk("rnd_cnt_model", int'(cnt_o), mc);

        // Complete any partial vector so the next section starts aligned
        for (int c = 0; c < 4 && cnt_o != 0; c++) begin
            s_valid = 1'b1;
            s_data  = 8'sd0;
            tick();
        end
        s_valid = 1'b0;
        tick();

        // Reset mid-vector with a result pending
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data  = (k < 4) ? 8'sd64 : 8'sd100;
            tick();
        end
        s_valid = 1'b0;
        chk("pre_rst_valid", int'(m_valid), 1);
        chk("pre_rst_cnt", int'(cnt_o), 2);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_cnt", int'(cnt_o), 0);
        #4 rst_n = 1'b1;
        m_ready = 1'b1;
        tick();
        chk("post_rst_valid", int'(m_valid), 0);
        for (int k = 0; k < 4; k++) begin
            s_valid = 1'b1;
            s_data  = 8'sd16;
            tick();
            if (k < 3) chk($sformatf("post_rst_idle%0d", k), int'(m_valid), 0);
        end
        s_valid = 1'b0;
        $display("post reset: m_data=%0d m_sat=%0d", sdata(), m_sat);
        chk("post_rst_out_valid", int'(m_valid), 1);
        chk("post_rst_out_data", sdata(), 4);
        chk("post_rst_out_sat", int'(m_sat), 0);
        tick();
        chk("post_rst_done", int'(m_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
